// File: rtl/ahb_ram_slave.sv
// ahb_ram_slave: AHB-lite responder in front of a word-organised on-chip RAM.
// Supports byte/halfword/word writes on little-endian lanes, a fixed number of
// data-phase wait states and the two-cycle ERROR response for illegal accesses.
//
// Handshake: an address phase is taken only when sel && ready_in && trans[1]
// while this slave is itself ready (IDLE, DATA or ERR2). The transfer then
// completes in the first later cycle where ready_out = 1 (DATA or ERR2).
module ahb_ram_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [1:0]  trans,
    input  logic        ready_in,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready_out,
    output logic        resp
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t          state;
    logic [2:0]      count;
    logic            req_write;
    logic [1:0]      req_size;
    logic [1:0]      req_lane;
    logic [AW-1:0]   req_idx;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic            a_aligned;
    logic            a_in_range;
    logic            a_legal;
    logic [AW-1:0]   a_idx;
    logic [3:0]      wr_lanes;
    logic [31:0]     merged;
    logic            commit;

    // NONSEQ/SEQ is recognised by trans[1] alone; BUSY/IDLE differ only in bit 0.
    logic            unused_trans_lsb;
    assign unused_trans_lsb = trans[0];

    assign accept     = sel && ready_in && trans[1] &&
                        ((state == S_IDLE) || (state == S_DATA) || (state == S_ERR2));
    assign a_idx      = addr[AW+1:2];
    assign a_in_range = ((addr >> (AW + 2)) == 32'd0);
    assign a_legal    = a_aligned && a_in_range;
    assign commit     = (state == S_DATA) && req_write;

    assign ready_out  = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign resp       = (state == S_ERR1) || (state == S_ERR2);

    // Size/alignment legality of the address phase currently on the bus.
    always_comb begin
        a_aligned = 1'b0;
        case (size)
            2'd0:    a_aligned = 1'b1;
            2'd1:    a_aligned = !addr[0];
            2'd2:    a_aligned = (addr[1:0] == 2'b00);
            default: a_aligned = 1'b0;
        endcase
    end

    // Byte lanes touched by the registered transfer.
    always_comb begin
        wr_lanes = 4'b0000;
        case (req_size)
            2'd0:    wr_lanes = 4'b0001 << req_lane;
            2'd1:    wr_lanes = req_lane[1] ? 4'b1100 : 4'b0011;
            default: wr_lanes = 4'b1111;
        endcase
    end

    // Post-write word: write data on the addressed lanes, old RAM bytes elsewhere.
    always_comb begin
        merged = mem[req_idx];
        for (int i = 0; i < 4; i++) begin
            if (wr_lanes[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    // RAM write port: commits at the edge that ends a write's DATA cycle.
    always_ff @(posedge clk) begin
        if (commit) mem[req_idx] <= merged;
    end

    // Transfer FSM with request registers, wait counter and read data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            count     <= 3'd0;
            rdata     <= 32'd0;
            req_write <= 1'b0;
            req_size  <= 2'd0;
            req_lane  <= 2'd0;
            req_idx   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DATA, S_ERR2: begin
                    if (accept) begin
                        req_write <= write;
                        req_size  <= size;
                        req_lane  <= addr[1:0];
                        req_idx   <= a_idx;
                        if (!a_legal) begin
                            state <= S_ERR1;
                        end else if (WAIT_STATES == 0) begin
                            state <= S_DATA;
                            // Zero-wait read: fetch now; bypass a write committing this edge.
                            if (!write) begin
                                if (commit && (a_idx == req_idx)) rdata <= merged;
                                else                              rdata <= mem[a_idx];
                            end
                        end else begin
                            state <= S_WAIT;
                            count <= WAIT_LOAD;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (count == 3'd0) begin
                        state <= S_DATA;
                        // Any earlier write already committed before this edge.
                        if (!req_write) rdata <= mem[req_idx];
                    end else begin
                        count <= count - 3'd1;
                    end
                end
                S_ERR1: begin
                    state <= S_ERR2;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
